// File: rtl/dmem_pkg.sv
// dmem_pkg: address map, TXSTAT layout and default sizes shared by the
// data-memory bus controller and its TX FIFO.
package dmem_pkg;

  localparam int unsigned DEF_RAM_WORDS = 256;
  localparam int unsigned DEF_TX_DEPTH  = 4;

  localparam logic [31:0] ADDR_RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] ADDR_LED      = 32'h1000_0000;
  localparam logic [31:0] ADDR_CYCLE    = 32'h1000_0004;
  localparam logic [31:0] ADDR_TXDATA   = 32'h1000_0008;
  localparam logic [31:0] ADDR_TXSTAT   = 32'h1000_000C;

  localparam int TXSTAT_OVF_BIT   = 31;
  localparam int TXSTAT_EMPTY_BIT = 9;
  localparam int TXSTAT_FULL_BIT  = 8;
  localparam int TXSTAT_COUNT_LSB = 0;
  localparam int TXSTAT_COUNT_W   = 3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_CYCLE,
    SEL_TXDATA,
    SEL_TXSTAT
  } sel_e;

  // Map a byte address to its target; the two byte-offset bits never matter.
  function automatic sel_e decode(input logic [31:0] addr, input int unsigned ram_words);
    logic [31:0] word_addr;
    word_addr = {addr[31:2], 2'b00};
    if ((word_addr - ADDR_RAM_BASE) < 32'(4 * ram_words)) return SEL_RAM;
    else if (word_addr == ADDR_LED)    return SEL_LED;
    else if (word_addr == ADDR_CYCLE)  return SEL_CYCLE;
    else if (word_addr == ADDR_TXDATA) return SEL_TXDATA;
    else if (word_addr == ADDR_TXSTAT) return SEL_TXSTAT;
    else                               return SEL_NONE;
  endfunction

  // Assemble the TXSTAT read word from the FIFO status bits.
  function automatic logic [31:0] txstat_word(input logic ovf, input logic empty,
                                              input logic full,
                                              input logic [TXSTAT_COUNT_W-1:0] count);
    logic [31:0] w;
    w = '0;
    w[TXSTAT_OVF_BIT]   = ovf;
    w[TXSTAT_EMPTY_BIT] = empty;
    w[TXSTAT_FULL_BIT]  = full;
    w[TXSTAT_COUNT_LSB +: TXSTAT_COUNT_W] = count;
    return w;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: registered FIFO feeding the TX consumer. A push into an empty FIFO
// becomes visible the following cycle (no fall-through). A push that finds the
// FIFO full is accepted only if the head leaves in the same cycle; otherwise it
// is dropped and the sticky overflow flag is raised.
module tx_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_TX_DEPTH,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     ready,
  input  logic                     ovf_clr,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign valid   = !empty;
  assign do_pop  = valid && ready;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers, occupancy and the sticky overflow flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (ovf_clr)   ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
    end
  end

  // Entry storage.
  // NOTE: storage arrays are not reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl: single-cycle CPU data-memory bus. Decodes the byte address
// onto word RAM, an LED register, a free-running CYCLE counter, and a TX FIFO
// with its status word. Loads are combinational; stores commit on the edge.
// The CYCLE counter exists only when DMEM_CYCLE_COUNTER_EN is defined; without
// it CYCLE reads 0 and writes to it are ignored.
module dmem_bus_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = DEF_RAM_WORDS,
  parameter int unsigned TX_DEPTH  = DEF_TX_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  LED,
  output logic [31:0] TxData,
  output logic        TxValid,
  input  logic        TxReady
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

  sel_e                      sel;
  logic [RAM_AW-1:0]         ram_idx;
  logic [31:0]               ram [RAM_WORDS];
  logic [31:0]               cycle_cnt;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_ovf;
  logic [$clog2(TX_DEPTH):0] fifo_count;
  logic [TXSTAT_COUNT_W-1:0] count3;

  assign sel     = decode(ALUResult, RAM_WORDS);
  assign ram_idx = ALUResult[RAM_AW+1:2];
  assign count3  = TXSTAT_COUNT_W'(fifo_count);

  // Word RAM store port; contents survive reset.
  always_ff @(posedge clk) begin
    if (MemWrite && sel == SEL_RAM) ram[ram_idx] <= WriteData;
  end

  // LED register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         LED <= '0;
    else if (MemWrite && sel == SEL_LED) LED <= WriteData[7:0];
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  // Free-running cycle counter; a store to CYCLE restarts it from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            cycle_cnt <= '0;
    else if (MemWrite && sel == SEL_CYCLE) cycle_cnt <= '0;
    else                                   cycle_cnt <= cycle_cnt + 32'd1;
  end
`else
  assign cycle_cnt = '0;
`endif

  tx_fifo #(
    .DEPTH(TX_DEPTH),
    .WIDTH(32)
  ) u_tx_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (MemWrite && sel == SEL_TXDATA),
    .push_data(WriteData),
    .ready    (TxReady),
    .ovf_clr  (MemWrite && sel == SEL_TXSTAT),
    .head     (TxData),
    .valid    (TxValid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .ovf      (fifo_ovf)
  );

  // Zero-latency load mux; TXDATA and unmapped addresses read as zero.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    ReadData = '0;
    case (sel)
      SEL_RAM:    ReadData = ram[ram_idx];
      SEL_LED:    ReadData = {24'b0, LED};
      SEL_CYCLE:  ReadData = cycle_cnt;
      SEL_TXSTAT: ReadData = txstat_word(fifo_ovf, fifo_empty, fifo_full, count3);
      default:    ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb_dmem_bus_ctrl: directed plus randomized bus traffic against a behavioural
// model of the memory map. Expected load data is queued when a bus cycle is
// issued; a negedge monitor pops and compares it, and also compares the LED
// and TX outputs against the model every cycle.
module tb_dmem_bus_ctrl;

  localparam int RAM_WORDS = 256;
  localparam int TX_DEPTH  = 4;
  localparam logic [31:0] A_LED = 32'h1000_0000;
  localparam logic [31:0] A_CYC = 32'h1000_0004;
  localparam logic [31:0] A_TXD = 32'h1000_0008;
  localparam logic [31:0] A_TXS = 32'h1000_000C;
  localparam logic [31:0] A_UNM = 32'h2000_0000;
  localparam logic [31:0] A_END = 32'(4 * RAM_WORDS);

`ifdef DMEM_CYCLE_COUNTER_EN
  localparam bit CYCLE_EN = 1'b1;
`else
  localparam bit CYCLE_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  LED;
  logic [31:0] TxData;
  logic        TxValid;
  logic        TxReady;

  dmem_bus_ctrl #(
    .RAM_WORDS(RAM_WORDS),
    .TX_DEPTH (TX_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .LED      (LED),
    .TxData   (TxData),
    .TxValid  (TxValid),
    .TxReady  (TxReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Behavioural model of the memory map.
  logic [31:0] m_ram [int];
  logic [7:0]  m_led   = '0;
  logic [31:0] m_cycle = '0;
  logic        m_ovf   = 1'b0;
  logic [31:0] m_fifo [$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_t;
  rd_t         rd_q [$];
  logic        rd_chk = 1'b0;
  logic [31:0] got_q [$];

  task automatic model_reset();
    m_led   = '0;
    m_cycle = '0;
    m_ovf   = 1'b0;
    m_fifo.delete();
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [31:0] a;
    int          n;
    logic [2:0]  c3;
    a  = addr & ~32'd3;
    n  = m_fifo.size();
    c3 = 3'(n);
    if (a < A_END) return m_ram.exists(int'(a >> 2)) ? m_ram[int'(a >> 2)] : 32'hxxxx_xxxx;
    if (a == A_LED) return {24'b0, m_led};
    if (a == A_CYC) return m_cycle;
    if (a == A_TXS) return {m_ovf, 21'b0, n == 0, n == TX_DEPTH, 5'b0, c3};
    return 32'h0;
  endfunction

  task automatic model_step(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic ready);
    logic [31:0] a;
    bit          pop;
    bit          full;
    a    = addr & ~32'd3;
    pop  = (m_fifo.size() != 0) && ready;
    full = (m_fifo.size() == TX_DEPTH);
    if (pop) void'(m_fifo.pop_front());
    if (CYCLE_EN) m_cycle = m_cycle + 32'd1;
    if (we) begin
      if (a < A_END)       m_ram[int'(a >> 2)] = wdata;
      else if (a == A_LED) m_led = wdata[7:0];
      else if (a == A_CYC) m_cycle = '0;
      else if (a == A_TXD) begin
        if (!full || pop) m_fifo.push_back(wdata);
        else              m_ovf = 1'b1;
      end
      else if (a == A_TXS) m_ovf = 1'b0;
    end
  endtask

  // One bus cycle, entered and left #1 after a rising edge.
  task automatic bus_cycle(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic ready);
    logic [31:0] exp;
    MemWrite  = we;
    ALUResult = addr;
    WriteData = wdata;
    TxReady   = ready;
    exp = model_read(addr);
    if (!$isunknown(exp)) begin
      rd_q.push_back('{addr: addr, exp: exp});
      rd_chk = 1'b1;
    end
    @(posedge clk);
    model_step(we, addr, wdata, ready);
    #1;
    rd_chk = 1'b0;
  endtask

  // Monitor: compares DUT outputs with the model away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      check("txvalid", {31'b0, TxValid}, {31'b0, m_fifo.size() != 0});
      check("txdata", TxData, (m_fifo.size() != 0) ? m_fifo[0] : 32'h0);
      check("led", {24'b0, LED}, {24'b0, m_led});
      if (TxValid && TxReady) got_q.push_back(TxData);
      if (rd_chk) begin
        if (rd_q.size() == 0) begin
          check("rd_queue_underflow", 32'd0, 32'd1);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          check($sformatf("readdata@%08h", r.addr), ReadData, r.exp);
        end
      end
    end
  end

  initial begin
    logic [31:0] drain_exp [5];
    reset     = 1'b1;
    MemWrite  = 1'b0;
    ALUResult = '0;
    WriteData = '0;
    TxReady   = 1'b0;

    // Reset state.
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_txvalid", {31'b0, TxValid}, 32'd0);
    check("rst_txdata", TxData, 32'd0);
    check("rst_led", {24'b0, LED}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // CYCLE counts edges since reset release; a store restarts it at zero.
    for (int i = 0; i < 10; i++) bus_cycle(1'b0, A_UNM, 32'h0, 1'b0);
    bus_cycle(1'b0, A_CYC, 32'h0, 1'b0);
    bus_cycle(1'b1, A_CYC, 32'hFFFF_FFFF, 1'b0);
    bus_cycle(1'b0, A_CYC, 32'h0, 1'b0);
    bus_cycle(1'b0, A_CYC, 32'h0, 1'b0);

    // RAM, its upper boundary and unmapped space.
    bus_cycle(1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0);
    bus_cycle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    bus_cycle(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    check("ram_0x10_direct", ReadData, 32'hDEAD_BEEF);
    bus_cycle(1'b0, 32'h0000_0013, 32'h0, 1'b0);
    bus_cycle(1'b1, A_END - 32'd4, 32'hCAFE_F00D, 1'b0);
    bus_cycle(1'b0, A_END - 32'd4, 32'h0, 1'b0);
    bus_cycle(1'b1, A_END, 32'hBAD0_BAD0, 1'b0);
    bus_cycle(1'b0, A_END, 32'h0, 1'b0);
    bus_cycle(1'b0, 32'h0000_0000, 32'h0, 1'b0);
    bus_cycle(1'b0, A_UNM, 32'h0, 1'b0);
    check("unmapped_direct", ReadData, 32'h0);

    // LED register.
    bus_cycle(1'b1, A_LED, 32'h1234_56A5, 1'b0);
    bus_cycle(1'b0, A_LED, 32'h0, 1'b0);
    check("led_read_direct", ReadData, 32'h0000_00A5);
    check("led_port_direct", {24'b0, LED}, 32'h0000_00A5);

    // Fill past full with the consumer stalled.
    for (int i = 1; i <= 5; i++) bus_cycle(1'b1, A_TXD, 32'(i), 1'b0);
    bus_cycle(1'b0, A_TXS, 32'h0, 1'b0);
    check("txstat_full_direct", ReadData, 32'h8000_0104);
    check("txdata_head_direct", TxData, 32'd1);
    bus_cycle(1'b1, A_TXS, 32'h0, 1'b0);
    bus_cycle(1'b0, A_TXS, 32'h0, 1'b0);
    check("txstat_ovf_clr_direct", ReadData, 32'h0000_0104);
    bus_cycle(1'b0, A_TXD, 32'h0, 1'b0);

    // Push into a full FIFO while it pops, then drain.
    got_q.delete();
    bus_cycle(1'b1, A_TXD, 32'd6, 1'b1);
    bus_cycle(1'b0, A_TXS, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) bus_cycle(1'b0, A_UNM, 32'h0, 1'b1);
    drain_exp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd6};
    check("drain_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("drain_%0d", i), (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF, drain_exp[i]);
    bus_cycle(1'b0, A_TXS, 32'h0, 1'b0);

    // Push into empty, then reset mid-operation with three entries held.
    bus_cycle(1'b1, A_TXD, 32'd7, 1'b0);
    check("txvalid_after_push", {31'b0, TxValid}, 32'd1);
    bus_cycle(1'b1, A_TXD, 32'd8, 1'b0);
    bus_cycle(1'b1, A_TXD, 32'd9, 1'b0);
    MemWrite = 1'b0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("midrst_txvalid", {31'b0, TxValid}, 32'd0);
    check("midrst_txdata", TxData, 32'd0);
    check("midrst_led", {24'b0, LED}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus_cycle(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    bus_cycle(1'b0, A_TXS, 32'h0, 1'b0);

    // Randomized traffic over a small working set of RAM words.
    for (int i = 0; i < 16; i++) bus_cycle(1'b1, 32'(i * 4), $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 600; i++) begin
      logic [31:0] addr;
      logic        we;
      int          op;
      op = $urandom_range(0, 11);
      we = 1'($urandom_range(0, 1));
      case (op)
        0, 1, 2, 3: addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        4:          addr = A_LED;
        5:          addr = A_CYC;
        6, 7, 8:    addr = A_TXD;
        9:          addr = A_TXS;
        10:         addr = A_END;
        default:    addr = ($urandom_range(0, 1) != 0) ? A_UNM : 32'h1000_0010;
      endcase
      if (op == 9 && $urandom_range(0, 3) != 0) we = 1'b0;
      bus_cycle(we, addr, $urandom, 1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 8; i++) bus_cycle(1'b0, A_TXS, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
